// File: rtl/gray_gauss3x3_if.sv
// Stream bundle between the gray converter, the 3x3 Gaussian stage and its consumer.
// master = side that drives pixels in and takes results; slave = the filter.
interface gray_gauss3x3_if;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       in_sof;
  logic       out_valid;
  logic [7:0] out_pixel;
  logic       out_sof;
  logic       out_eof;
  logic       busy;

  modport master (
    output in_valid, in_pixel, in_sof,
    input  out_valid, out_pixel, out_sof, out_eof, busy
  );

  modport slave (
    input  in_valid, in_pixel, in_sof,
    output out_valid, out_pixel, out_sof, out_eof, busy
  );
endinterface

// File: rtl/gray_gauss3x3.sv
// Streaming 3x3 Gaussian smoother [1 2 1; 2 4 2; 1 2 1] / 16 over a raster gray stream.
// Two line buffers feed a sliding window; emits the (IMG_W-2) x (IMG_H-2) interior, 2 cycles after each producing beat.
module gray_gauss3x3 #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_gauss3x3_if.slave bus
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] col, pcol;
  logic [RW-1:0] row, prow;
  logic          accept, produce, last_beat;

  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    lb0_rd, lb1_rd;

  // Left two window columns; the right column is the incoming {lb1, lb0, in_pixel}.
  logic [7:0]    win  [3][2];
  logic [7:0]    ncol [3];
  logic [9:0]    rsum_c [3];

  logic          s1_valid, s1_sof, s1_eof;
  logic [9:0]    s1_r [3];
  logic [11:0]   sum_c;

  // Beat qualification and position; an in_sof beat is always (0,0).
  always_comb begin
    accept    = bus.in_valid && (bus.in_sof || state == FILL || state == STREAM);
    pcol      = bus.in_sof ? '0 : col;
    prow      = bus.in_sof ? '0 : row;
    lb0_rd    = lb0[pcol];
    lb1_rd    = lb1[pcol];
    ncol[0]   = lb1_rd;
    ncol[1]   = lb0_rd;
    ncol[2]   = bus.in_pixel;
    produce   = accept && (prow >= RW'(2)) && (pcol >= CW'(2));
    last_beat = (prow == RW'(IMG_H - 1)) && (pcol == CW'(IMG_W - 1));
    for (int i = 0; i < 3; i++) begin
      rsum_c[i] = 10'(win[i][0]) + (10'(win[i][1]) << 1) + 10'(ncol[i]);
    end
    sum_c = 12'(s1_r[0]) + (12'(s1_r[1]) << 1) + 12'(s1_r[2]);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = FILL;
      FILL:    if (accept && prow == RW'(2)) state_next = STREAM;
      STREAM:  if (accept) begin
                 if (bus.in_sof)     state_next = FILL;
                 else if (last_beat) state_next = DRAIN;
               end
      DRAIN:   if (accept)         state_next = FILL;
               else if (!s1_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
    end else begin
      state    <= state_next;
      bus.busy <= (state_next != IDLE);
    end
  end

  // Raster counters and window shift, both only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= '0;
        win[i][1] <= '0;
      end
    end else if (accept) begin
      if (pcol == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= last_beat ? '0 : prow + RW'(1);
      end else begin
        col <= pcol + CW'(1);
        row <= prow;
      end
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= ncol[i];
      end
    end
  end

  // Line buffers: contents need no reset, reads above see pre-write data.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[pcol] <= bus.in_pixel;
      lb1[pcol] <= lb0_rd;
    end
  end

  // Stage 1 row sums, stage 2 final sum; valid tags advance every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_sof        <= 1'b0;
      s1_eof        <= 1'b0;
      for (int i = 0; i < 3; i++) s1_r[i] <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
      bus.out_pixel <= '0;
    end else begin
      s1_valid      <= produce;
      s1_sof        <= produce && (prow == RW'(2)) && (pcol == CW'(2));
      s1_eof        <= produce && last_beat;
      for (int i = 0; i < 3; i++) s1_r[i] <= rsum_c[i];
      bus.out_valid <= s1_valid;
      bus.out_sof   <= s1_sof;
      bus.out_eof   <= s1_eof;
      bus.out_pixel <= 8'(sum_c >> 4);
    end
  end

endmodule
